// File: rtl/vga_box_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_box_engine
// Purpose  : N-box sprite engine. Per-frame box motion, priority pixel colour
//            generation and per-frame overlap (collision) reporting.
// Revision : 1.0 - initial release
// ============================================================================
module vga_box_engine #(
    parameter int NUM_BOXES = 4,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BOX_W     = 32,
    parameter int BOX_H     = 32,
    parameter int SLOW_STEP = 2,
    parameter int FAST_STEP = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          h_counter,
    input  logic [11:0]          v_counter,
    input  logic                 v_sync,
    input  logic [1:0]           mode,
    input  logic [NUM_BOXES-1:0] box_en,
    input  logic                 mv_left,
    input  logic                 mv_right,
    input  logic                 mv_up,
    input  logic                 mv_down,
    input  logic                 fast,
    input  logic                 color_alt,
    output logic [7:0]           red,
    output logic [7:0]           green,
    output logic [7:0]           blue,
    output logic                 collision,
    output logic [15:0]          frame_count
);

    localparam logic [11:0] XMAX        = 12'(H_ACTIVE - BOX_W);
    localparam logic [11:0] YMAX        = 12'(V_ACTIVE - BOX_H);
    localparam logic [1:0]  MODE_WRAP   = 2'b01;
    localparam logic [1:0]  MODE_CLAMP  = 2'b10;
    localparam logic [1:0]  MODE_BOUNCE = 2'b11;

    // Returns {direction_negative, next_position} for one axis.
    function automatic logic [12:0] axis_next(
        input logic [11:0] pos,
        input logic [11:0] max,
        input logic [11:0] step,
        input logic [1:0]  md,
        input logic        inc,
        input logic        dec,
        input logic        neg
    );
        logic [12:0] up;
        logic [11:0] dn;
        logic [11:0] p;
        logic        n;
        up = {1'b0, pos} + {1'b0, step};
        dn = pos - step;
        p  = pos;
        n  = neg;
        case (md)
            MODE_WRAP: begin
                if (inc && !dec)
                    p = (up > {1'b0, max}) ? 12'd0 : up[11:0];
                else if (dec && !inc)
                    p = (pos < step) ? max : dn;
            end
            MODE_CLAMP: begin
                if (inc && !dec)
                    p = (up > {1'b0, max}) ? max : up[11:0];
                else if (dec && !inc)
                    p = (pos < step) ? 12'd0 : dn;
            end
            MODE_BOUNCE: begin
                if (!neg) begin
                    if (up >= {1'b0, max}) begin
                        p = max;
                        n = 1'b1;
                    end else begin
                        p = up[11:0];
                    end
                end else begin
                    if (pos <= step) begin
                        p = 12'd0;
                        n = 1'b0;
                    end else begin
                        p = dn;
                    end
                end
            end
            default: ;
        endcase
        return {n, p};
    endfunction

    function automatic logic [23:0] palette(input logic [1:0] idx, input logic alt);
        logic [23:0] c;
        case (idx)
            2'd0:    c = 24'hFF0000;
            2'd1:    c = 24'h0000FF;
            2'd2:    c = 24'h00FF00;
            default: c = 24'hFFFFFF;
        endcase
        return alt ? ~c : c;
    endfunction

    logic [2:0]           sync_q;
    logic                 strobe_q;
    logic                 acc_q;
    logic                 collision_q;
    logic [15:0]          frame_count_q;
    logic [23:0]          rgb_q;
    logic [23:0]          rgb_d;
    logic                 multi_d;
    logic                 active_w;
    logic [11:0]          step_w;
    logic [NUM_BOXES-1:0] hit_w;

    assign step_w   = fast ? 12'(FAST_STEP) : 12'(SLOW_STEP);
    assign active_w = (h_counter < 12'(H_ACTIVE)) && (v_counter < 12'(V_ACTIVE));

    for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_box
        logic [11:0] x_q, y_q;
        logic        xneg_q, yneg_q;
        logic [12:0] x_d, y_d;

        assign x_d = axis_next(x_q, XMAX, step_w, mode, mv_right, mv_left, xneg_q);
        assign y_d = axis_next(y_q, YMAX, step_w, mode, mv_down, mv_up, yneg_q);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                x_q    <= 12'(gi * 2 * BOX_W);
                y_q    <= 12'(gi * 2 * BOX_H);
                xneg_q <= 1'b0;
                yneg_q <= 1'b0;
            end else if (strobe_q && box_en[gi]) begin
                x_q    <= x_d[11:0];
                xneg_q <= x_d[12];
                y_q    <= y_d[11:0];
                yneg_q <= y_d[12];
            end
        end

        assign hit_w[gi] = active_w
            && (h_counter >= x_q) && ({1'b0, h_counter} < ({1'b0, x_q} + 13'(BOX_W)))
            && (v_counter >= y_q) && ({1'b0, v_counter} < ({1'b0, y_q} + 13'(BOX_H)));
    end

    // Walk from the highest index down so the lowest hit index lands last.
    always_comb begin
        rgb_d = 24'h000000;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (hit_w[i])
                rgb_d = palette(i[1:0], color_alt);
        end
        multi_d = ($countones(hit_w) > 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q        <= 3'b000;
            strobe_q      <= 1'b0;
            acc_q         <= 1'b0;
            collision_q   <= 1'b0;
            frame_count_q <= 16'd0;
            rgb_q         <= 24'h000000;
        end else begin
            sync_q   <= {sync_q[1:0], v_sync};
            strobe_q <= sync_q[1] & ~sync_q[2];
            rgb_q    <= rgb_d;
            if (strobe_q) begin
                collision_q   <= acc_q;
                acc_q         <= multi_d;
                frame_count_q <= frame_count_q + 16'd1;
            end else begin
                acc_q <= acc_q | multi_d;
            end
        end
    end

    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign collision   = collision_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire
